// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader for the writable instruction memory
module imem_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic [7:0]        ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  output logic              WriteEnable,
  output logic [ADDR_W-1:0] WriteAddress,
  output logic [DATA_W-1:0] WriteData,
  output logic              CpuHold,
  output logic              Done,
  output logic              Error
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] COUNT = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  logic [2:0]        state;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] widx;
  logic [ADDR_W-1:0] last_idx;
  logic [7:0]        csum;
  logic [23:0]       partial;
  logic              loading;
  logic              xfer;
  logic              count_bad;

  assign loading   = (state == COUNT) || (state == DATA) || (state == CHECK);
  assign ByteReady = loading;
  assign CpuHold   = loading;
  assign Done      = (state == DONE);
  assign Error     = (state == ERR);
  assign xfer      = ByteValid && loading;
  assign count_bad = (ByteIn == 8'd0) || (int'(ByteIn) > DEPTH);

  // Lanes 0..2 collect in a side buffer so WriteData only changes on a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lane         <= 2'd0;
      widx         <= '0;
      last_idx     <= '0;
      csum         <= 8'd0;
      partial      <= 24'd0;
      WriteEnable  <= 1'b0;
      WriteAddress <= '0;
      WriteData    <= '0;
    end else begin
      WriteEnable <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (Start) begin
            state <= COUNT;
            lane  <= 2'd0;
            widx  <= '0;
            csum  <= 8'd0;
          end
        end
        COUNT: begin
          if (xfer) begin
            if (count_bad) begin
              state <= ERR;
            end else begin
              last_idx <= ADDR_W'(ByteIn - 8'd1);
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            csum <= csum ^ ByteIn;
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              WriteEnable  <= 1'b1;
              WriteAddress <= widx;
              WriteData    <= DATA_W'({ByteIn, partial});
              // Index stops at N-1 so it can never wrap past the frame.
              if (widx == last_idx) state <= CHECK;
              else widx <= widx + 1'b1;
            end else begin
              case (lane)
                2'd0:    partial[7:0]   <= ByteIn;
                2'd1:    partial[15:8]  <= ByteIn;
                default: partial[23:16] <= ByteIn;
              endcase
            end
          end
        end
        CHECK: begin
          if (xfer) state <= (ByteIn == csum) ? DONE : ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
